multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter HALT_OP, default 6'b111111: the opcode that stops sequencing.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction register bits [31:26].
REQ-005 SHALL have port funct, input, 6 bits: instruction register bits [5:0].
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have outputs pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write and alu_src_a, each 1 bit: datapath enables and mux selects.
REQ-008 SHALL have outputs alu_src_b and pc_src, each 2 bits: datapath mux selects.
REQ-009 SHALL have output alu_ctl, 3 bits: ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-010 SHALL have output state, 4 bits: current FSM state, for debug.
REQ-011 SHALL have output halted, 1 bit: high while in HALT.
REQ-012 SHALL have output instr_count, 16 bits: count of retired instructions.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11 and HALT=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-014 SHALL have every output except instr_count be a pure function of state (plus zero and funct where stated below).
REQ-015 SHALL always go FETCH->DECODE.
REQ-016 SHALL branch from DECODE by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; HALT_OP -> HALT; any other opcode -> FETCH, retired as a NOP.
REQ-017 SHALL go MEMADR->MEMRD on opcode 100011 and MEMADR->MEMWR on 101011; it SHALL go MEMRD->MEMWB, EXEC->ALUWB and ADDIEX->ADDIWB.
REQ-018 SHALL go MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP to FETCH.
REQ-019 SHALL keep HALT in HALT until reset.
REQ-020 SHALL drive these signals in FETCH: ir_write=1, pc_en=1, alu_src_a=0, alu_src_b=01, pc_src=00, alu_ctl=010.
REQ-021 SHALL drive these signals in DECODE: alu_src_a=0, alu_src_b=11, alu_ctl=010.
REQ-022 SHALL drive alu_src_a=1, alu_src_b=10 and alu_ctl=010 in MEMADR and ADDIEX.
REQ-023 SHALL drive iord=1 in MEMRD.
REQ-024 SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0 in MEMWB.
REQ-025 SHALL drive iord=1 and mem_write=1 in MEMWR.
REQ-026 SHALL drive alu_src_a=1 and alu_src_b=00 in EXEC, with alu_ctl decoded from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
REQ-027 SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0 in ALUWB, and reg_write=1, reg_dst=0 and mem_to_reg=0 in ADDIWB.
REQ-028 SHALL drive alu_src_a=1, alu_src_b=00, alu_ctl=110 and pc_src=01 in BRANCH, with pc_en=zero combinationally.
REQ-029 SHALL drive pc_src=10 and pc_en=1 in JUMP.
REQ-030 SHALL drive all enables 0 and halted=1 in HALT.
REQ-031 SHALL drive 0 on any output not listed for a state.
REQ-032 SHALL increment instr_count by 1 on each edge that leaves MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP, or leaves DECODE on an unknown opcode; it SHALL wrap from 0xFFFF to 0x0000.
REQ-033 SHALL give these latencies from FETCH to the next FETCH: lw 5 cycles; sw, R-type and addi 4; beq and j 3; unknown opcode 2.

Reset
REQ-034 SHALL, on a rising edge with reset=1, set state to FETCH and instr_count to 0, from any state including mid-instruction and HALT.
REQ-035 SHALL force pc_en, ir_write, mem_write and reg_write to 0 while reset=1, and SHALL drive halted=0 in the same condition, so no datapath write occurs during reset.
REQ-036 SHALL give reset priority over every transition and over the instr_count increment on the same edge.

Verification
REQ-037 SHALL cover reset for 2 cycles then release with opcode=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1.
REQ-038 SHALL cover R-type with funct=101010 -> alu_ctl=111 in EXEC; reg_dst=1 and reg_write=1 in ALUWB; 4 cycles per instruction.
REQ-039 SHALL cover beq with zero=1 and then zero=0 -> pc_en=1 with pc_src=01 in BRANCH for the first, pc_en=0 for the second; both return to FETCH.
REQ-040 SHALL cover opcode=HALT_OP -> state=12, halted=1 and all enables 0 for 10 cycles, instr_count unchanged; then reset=1 -> FETCH.
REQ-041 SHALL cover reset=1 asserted during MEMWR -> no mem_write on that cycle; FETCH and instr_count=0 on the next edge.
REQ-042 SHALL cover instr_count preset to 0xFFFF via 65535 j instructions (or a forced value), then one more j -> instr_count=0x0000.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS-subset datapath.
// Sequences each instruction through its states and counts retired instructions.
module multicycle_control #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_ctl,
    output logic [3:0]  state,
    output logic        halted,
    output logic [15:0] instr_count
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd12;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0]  r_state;
    logic [15:0] r_instr_count;
    logic [3:0]  w_next;
    logic        w_retire;

    function automatic logic [2:0] alu_decode(input logic [5:0] fn);
        case (fn)
            6'b100000: alu_decode = 3'b010;
            6'b100010: alu_decode = 3'b110;
            6'b100100: alu_decode = 3'b000;
            6'b100101: alu_decode = 3'b001;
            6'b101010: alu_decode = 3'b111;
            default:   alu_decode = 3'b010;
        endcase
    endfunction

    // Next state; w_retire marks the edge on which an instruction completes.
    always_comb begin
        w_next   = S_FETCH;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) w_next = S_MEMADR;
                else if (opcode == OP_RTYPE)            w_next = S_EXEC;
                else if (opcode == OP_BEQ)              w_next = S_BRANCH;
                else if (opcode == OP_ADDI)             w_next = S_ADDIEX;
                else if (opcode == OP_J)                w_next = S_JUMP;
                else if (opcode == HALT_OP)             w_next = S_HALT;
                else begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_instr_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instr_count <= r_instr_count + 16'd1;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctl    = 3'b000;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_en     = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl   = 3'b010;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctl   = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctl   = alu_decode(funct);
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = 3'b110;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        // Reset suppresses every datapath write regardless of the current state.
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            halted    = 1'b0;
        end
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle output vectors are
// queued when an instruction is issued and compared as the FSM steps through it.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_ctl;
    logic [3:0]  state;
    logic        halted;
    logic [15:0] instr_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [19:0] sb_q[$];

    multicycle_control #(.HALT_OP(6'b111111)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_ctl(alu_ctl), .state(state), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [19:0] w_obs;
    assign w_obs = {state, pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst,
                    reg_write, alu_src_a, alu_src_b, pc_src, alu_ctl, halted};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Field order: pc_en iord mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a
    //              alu_src_b pc_src alu_ctl halted
    function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic [5:0] fn,
                                            input logic z);
        logic [15:0] o;
        logic [2:0]  alu;
        case (fn)
            6'b100000: alu = 3'b010;
            6'b100010: alu = 3'b110;
            6'b100100: alu = 3'b000;
            6'b100101: alu = 3'b001;
            6'b101010: alu = 3'b111;
            default:   alu = 3'b010;
        endcase
        case (st)
            4'd0:        o = 16'b1001_0000_01_00_010_0;
            4'd1:        o = 16'b0000_0000_11_00_010_0;
            4'd2, 4'd9:  o = 16'b0000_0001_10_00_010_0;
            4'd3:        o = 16'b0100_0000_00_00_000_0;
            4'd4:        o = 16'b0000_1010_00_00_000_0;
            4'd5:        o = 16'b0110_0000_00_00_000_0;
            4'd6:        o = {8'b0000_0001, 2'b00, 2'b00, alu, 1'b0};
            4'd7:        o = 16'b0000_0110_00_00_000_0;
            4'd8:        o = {z, 7'b000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
            4'd10:       o = 16'b0000_0010_00_00_000_0;
            4'd11:       o = 16'b1000_0000_00_10_000_0;
            4'd12:       o = 16'b0000_0000_00_00_000_1;
            default:     o = 16'd0;
        endcase
        return {st, o};
    endfunction

    task automatic push_states(input logic [3:0] st[], input logic [5:0] fn, input logic z);
        foreach (st[i]) sb_q.push_back(exp_vec(st[i], fn, z));
    endtask

    task automatic drain(input string tag);
        logic [19:0] e;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            check_vec(tag, {12'd0, w_obs}, {12'd0, e});
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one instruction (opcode/funct/zero held throughout) and check every cycle.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
        case (op)
            6'b100011: push_states('{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, fn, z);
            6'b101011: push_states('{4'd0, 4'd1, 4'd2, 4'd5}, fn, z);
            6'b000000: push_states('{4'd0, 4'd1, 4'd6, 4'd7}, fn, z);
            6'b000100: push_states('{4'd0, 4'd1, 4'd8}, fn, z);
            6'b001000: push_states('{4'd0, 4'd1, 4'd9, 4'd10}, fn, z);
            6'b000010: push_states('{4'd0, 4'd1, 4'd11}, fn, z);
            6'b111111: push_states('{4'd0, 4'd1, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12,
                                     4'd12, 4'd12, 4'd12, 4'd12, 4'd12}, fn, z);
            default:   push_states('{4'd0, 4'd1}, fn, z);
        endcase
        drain(tag);
        if (op != 6'b111111) exp_cnt = exp_cnt + 16'd1;
        check_vec({tag, "_cnt"}, {16'd0, instr_count}, {16'd0, exp_cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        opcode = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_vec("rst_outs", {12'd0, w_obs}, {12'd0, 4'd0, 16'b0000_0000_01_00_010_0});
        check_vec("rst_cnt", {16'd0, instr_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("lw",      6'b100011, 6'b000000, 1'b0);
        run_instr("r_slt",   6'b000000, 6'b101010, 1'b0);
        run_instr("r_add",   6'b000000, 6'b100000, 1'b0);
        run_instr("r_sub",   6'b000000, 6'b100010, 1'b1);
        run_instr("r_and",   6'b000000, 6'b100100, 1'b0);
        run_instr("r_or",    6'b000000, 6'b100101, 1'b0);
        run_instr("r_other", 6'b000000, 6'b000111, 1'b0);
        run_instr("beq_z1",  6'b000100, 6'b000000, 1'b1);
        run_instr("beq_z0",  6'b000100, 6'b000000, 1'b0);
        run_instr("addi",    6'b001000, 6'b000000, 1'b0);
        run_instr("j",       6'b000010, 6'b000000, 1'b0);
        run_instr("sw",      6'b101011, 6'b000000, 1'b0);
        run_instr("nop_op",  6'b010101, 6'b000000, 1'b0);

        // Reset arriving while in MEMWR.
        opcode = 6'b101011;
        push_states('{4'd0, 4'd1, 4'd2}, 6'd0, 1'b0);
        drain("sw_pre");
        reset = 1'b1;
        @(negedge clk);
        check_vec("rst_memwr_state", {28'd0, state}, 32'd5);
        check_vec("rst_memwr_mw", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        #1;
        check_vec("rst_memwr_fetch", {28'd0, state}, 32'd0);
        check_vec("rst_memwr_cnt", {16'd0, instr_count}, 32'd0);
        exp_cnt = 16'd0;
        reset = 1'b0;

        // Counter wrap: preset to 0xFFFF, then one jump.
        force dut.r_instr_count = 16'hFFFF;
        #1;
        release dut.r_instr_count;
        exp_cnt = 16'hFFFF;
        check_vec("preset_cnt", {16'd0, instr_count}, 32'h0000FFFF);
        run_instr("j_wrap", 6'b000010, 6'b000000, 1'b0);

        run_instr("lw2", 6'b100011, 6'b000000, 1'b0);
        run_instr("halt", 6'b111111, 6'b000000, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_vec("rst_halt_outs", {12'd0, w_obs}, {12'd0, 4'd12, 16'd0});
        @(posedge clk);
        #1;
        check_vec("rst_halt_fetch", {28'd0, state}, 32'd0);
        check_vec("rst_halt_cnt", {16'd0, instr_count}, 32'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
